// File: rtl/trigger_io.sv
// rtl/trigger_io.sv - push-button debounce/trigger stretcher and a0 light/change monitor
module trigger_io #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int HOLD_CYCLES     = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        btn,
    input  logic [31:0] a0,
    output logic        trigger,
    output logic [7:0]  lights,
    output logic        a0_change,
    output logic [15:0] press_count
);

    localparam int CNT_MAX = (DEBOUNCE_CYCLES > HOLD_CYCLES) ? DEBOUNCE_CYCLES : HOLD_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        DB_PRESS = 3'd1,
        FIRE     = 3'd2,
        WAIT_REL = 3'd3,
        DB_REL   = 3'd4
    } state_t;

    logic             s1_q;
    logic             btn_s_q;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             trigger_q;
    logic [15:0]      press_count_q, press_count_d;
    logic [31:0]      a0_q;
    logic [7:0]       lights_q;
    logic             a0_vld_q;
    logic             a0_change_q;

    // Two-flop synchroniser bringing the asynchronous button into the clk domain
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_q    <= 1'b0;
            btn_s_q <= 1'b0;
        end else begin
            s1_q    <= btn;
            btn_s_q <= s1_q;
        end
    end

    // Debounce FSM: next state, shared counter and saturating press counter
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        press_count_d = press_count_q;
        case (state_q)
            IDLE: begin
                if (btn_s_q) begin
                    state_d = DB_PRESS;
                    cnt_d   = '0;
                end
            end
            DB_PRESS: begin
                if (!btn_s_q) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == DB_LAST) begin
                    state_d = FIRE;
                    cnt_d   = '0;
                    if (press_count_q != 16'hFFFF) begin
                        press_count_d = press_count_q + 16'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            FIRE: begin
                // The button level is deliberately ignored while the pulse is stretched
                if (cnt_q == HOLD_LAST) begin
                    state_d = WAIT_REL;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            WAIT_REL: begin
                if (!btn_s_q) begin
                    state_d = DB_REL;
                    cnt_d   = '0;
                end
            end
            DB_REL: begin
                if (btn_s_q) begin
                    state_d = WAIT_REL;
                    cnt_d   = '0;
                end else if (cnt_q == DB_LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // FSM state, counter and registered trigger (high for every cycle spent in FIRE)
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            trigger_q     <= 1'b0;
            press_count_q <= 16'd0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            trigger_q     <= (state_d == FIRE);
            press_count_q <= press_count_d;
        end
    end

    // a0 monitor: mirror low byte onto lights and flag any change of the full word
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a0_q        <= 32'd0;
            lights_q    <= 8'd0;
            a0_vld_q    <= 1'b0;
            a0_change_q <= 1'b0;
        end else begin
            a0_q        <= a0;
            lights_q    <= a0[7:0];
            a0_vld_q    <= 1'b1;
            a0_change_q <= a0_vld_q && (a0 != a0_q);
        end
    end

    assign trigger     = trigger_q;
    assign lights      = lights_q;
    assign a0_change   = a0_change_q;
    assign press_count = press_count_q;

endmodule

// File: tb/tb_trigger_io.sv
// tb/tb_trigger_io.sv - directed, table-driven bench for trigger_io
module tb_trigger_io;

    logic        clk;
    logic        rst;
    logic        btn;
    logic [31:0] a0;
    logic        trigger;
    logic [7:0]  lights;
    logic        a0_change;
    logic [15:0] press_count;

    int n_cmp;
    int n_bad;
    int edge_no;
    int first_rise;
    int high_cnt;

    typedef struct {
        logic [31:0] a0;
        logic [7:0]  exp_lights;
        logic        exp_change;
    } a0_vec_t;

    a0_vec_t vecs [9];

    trigger_io #(
        .DEBOUNCE_CYCLES(16),
        .HOLD_CYCLES    (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .btn        (btn),
        .a0         (a0),
        .trigger    (trigger),
        .lights     (lights),
        .a0_change  (a0_change),
        .press_count(press_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_trace();
        edge_no    = 0;
        first_rise = -1;
        high_cnt   = 0;
    endtask

    task automatic drive(input logic b, input int n);
        btn = b;
        for (int i = 0; i < n; i++) begin
            tick();
            edge_no++;
            if (trigger === 1'b1) begin
                high_cnt++;
                if (first_rise < 0) first_rise = edge_no;
            end
        end
    endtask

    // Hold reset with activity on the inputs, then release just after an edge
    task automatic reset_dut();
        rst = 1'b0;
        btn = 1'b0;
        a0  = 32'd0;
        for (int i = 0; i < 4; i++) begin
            tick();
            btn = ~btn;
            a0  = a0 + 32'h0101_0101;
        end
        btn = 1'b0;
        a0  = 32'd0;
        tick();
        rst = 1'b1;
        clear_trace();
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst   = 1'b0;
        btn   = 1'b0;
        a0    = 32'd0;

        vecs[0] = '{32'h0000_0055, 8'h55, 1'b0};
        vecs[1] = '{32'h0000_0000, 8'h00, 1'b1};
        vecs[2] = '{32'h0000_0000, 8'h00, 1'b0};
        vecs[3] = '{32'h0000_00FF, 8'hFF, 1'b1};
        vecs[4] = '{32'h0001_00FF, 8'hFF, 1'b1};
        vecs[5] = '{32'h0001_00FF, 8'hFF, 1'b0};
        vecs[6] = '{32'h8001_00FF, 8'hFF, 1'b1};
        vecs[7] = '{32'h8001_00FF, 8'hFF, 1'b0};
        vecs[8] = '{32'h1234_5678, 8'h78, 1'b1};

        // T1: reset holds every output low despite input activity
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            btn = ~btn;
            a0  = a0 ^ 32'hDEAD_BEEF;
            tick();
        end
        check("rst_trigger", {31'd0, trigger}, 32'd0);
        check("rst_lights", {24'd0, lights}, 32'd0);
        check("rst_a0_change", {31'd0, a0_change}, 32'd0);
        check("rst_press_count", {16'd0, press_count}, 32'd0);
        reset_dut();
        drive(1'b0, 25);
        check("idle_no_trigger", high_cnt, 0);

        // T5: a0 monitor table, starting right after reset so the first edge cannot pulse
        reset_dut();
        for (int i = 0; i < 9; i++) begin
            a0 = vecs[i].a0;
            tick();
            check($sformatf("a0_lights[%0d]", i), {24'd0, lights}, {24'd0, vecs[i].exp_lights});
            check($sformatf("a0_change[%0d]", i), {31'd0, a0_change}, {31'd0, vecs[i].exp_change});
        end

        // T2: clean press held for 40 cycles, with an a0 change landing on the firing edge
        reset_dut();
        drive(1'b1, 18);
        check("t2_no_early_trigger", high_cnt, 0);
        a0 = 32'h0000_ABCD;
        drive(1'b1, 1);
        check("t2_rise_edge", first_rise, 19);
        check("t2_sim_trigger", {31'd0, trigger}, 32'd1);
        check("t2_sim_a0_change", {31'd0, a0_change}, 32'd1);
        check("t2_sim_lights", {24'd0, lights}, 32'h0000_00CD);
        check("t2_sim_press_count", {16'd0, press_count}, 32'd1);
        drive(1'b1, 21);
        check("t2_pulse_width", high_cnt, 4);
        check("t2_press_count", {16'd0, press_count}, 32'd1);

        // T4: short release is rejected, a debounced release arms the next press
        clear_trace();
        drive(1'b0, 5);
        drive(1'b1, 30);
        check("t4_short_release", high_cnt, 0);
        check("t4_count_after_short", {16'd0, press_count}, 32'd1);
        drive(1'b0, 20);
        clear_trace();
        drive(1'b1, 30);
        check("t4_second_pulse", high_cnt, 4);
        check("t4_second_rise", first_rise, 19);
        check("t4_press_count", {16'd0, press_count}, 32'd2);

        // T3: bounce in the middle of a press never fires
        reset_dut();
        drive(1'b1, 10);
        drive(1'b0, 1);
        drive(1'b1, 10);
        drive(1'b0, 30);
        check("t3_bounce_trigger", high_cnt, 0);
        check("t3_bounce_count", {16'd0, press_count}, 32'd0);

        // T6: asynchronous reset while firing, then a full fresh debounce
        reset_dut();
        drive(1'b1, 20);
        check("t6_firing", {31'd0, trigger}, 32'd1);
        #2;
        rst = 1'b0;
        #1;
        check("t6_async_trigger", {31'd0, trigger}, 32'd0);
        check("t6_async_count", {16'd0, press_count}, 32'd0);
        #1;
        rst = 1'b1;
        clear_trace();
        drive(1'b1, 25);
        check("t6_rise_after_reset", first_rise, 19);
        check("t6_pulse_width", high_cnt, 4);
        check("t6_press_count", {16'd0, press_count}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
